// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NRD combinational read ports
// with write-first bypass, a hardwired-zero register, and a post-reset sweep
// that fills every register with its index (or zero) before writes are accepted.
module regfile_mp #(
  parameter int DW       = 64,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int ZREG     = 31,
  parameter int INIT_IDX = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_a,
  input  logic [AW-1:0]     wa_a,
  input  logic [DW-1:0]     wd_a,
  input  logic              we_b,
  input  logic [AW-1:0]     wa_b,
  input  logic [DW-1:0]     wd_b,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*DW-1:0] rd,
  output logic              ready
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [AW:0]   NREG_W   = (AW+1)'(NREG);
  localparam logic [AW-1:0] ZREG_A   = AW'(ZREG);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  state_t          state_r, state_n;
  logic [AW-1:0]   idx_r, idx_n;
  logic            ready_r, ready_n;
  logic [DW-1:0]   mem_r [NREG];
  logic [DW-1:0]   init_val_s;
  logic            wen_a_s, wen_b_s;

  // An address is usable only if it names a real register other than the zero register.
  function automatic logic addr_ok(input logic [AW-1:0] addr);
    return ({1'b0, addr} < NREG_W) && (addr != ZREG_A);
  endfunction

  assign init_val_s = (INIT_IDX != 0) ? DW'(idx_r) : '0;
  assign wen_a_s    = (state_r == ST_RUN) && we_a && addr_ok(wa_a);
  assign wen_b_s    = (state_r == ST_RUN) && we_b && addr_ok(wa_b);
  assign ready      = ready_r;

  // Control state: asynchronous reset restarts the sweep from index 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_INIT;
      idx_r   <= '0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_n;
      idx_r   <= idx_n;
      ready_r <= ready_n;
    end
  end

  // Next-state: step the sweep counter and enter RUN on the edge that writes the last register.
  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    ready_n = ready_r;
    case (state_r)
      ST_INIT: begin
        ready_n = 1'b0;
        if (idx_r == LAST_IDX) begin
          state_n = ST_RUN;
          idx_n   = '0;
          ready_n = 1'b1;
        end else begin
          idx_n = idx_r + AW'(1);
        end
      end
      ST_RUN: begin
        ready_n = 1'b1;
      end
      default: begin
        state_n = ST_INIT;
        idx_n   = '0;
        ready_n = 1'b0;
      end
    endcase
  end

  // Storage: sweep write during INIT; in RUN port B is applied last so it wins on a collision.
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      mem_r[idx_r] <= init_val_s;
    end else begin
      if (wen_a_s) begin
        mem_r[wa_a] <= wd_a;
      end
      if (wen_b_s) begin
        mem_r[wa_b] <= wd_b;
      end
    end
  end

  // Read ports: zero outside RUN or for unusable addresses, otherwise write-first bypass (B over A).
  always_comb begin
    rd = '0;
    for (int k = 0; k < NRD; k++) begin
      logic [AW-1:0] ra_k;
      ra_k = ra[k*AW +: AW];
      if ((state_r == ST_RUN) && addr_ok(ra_k)) begin
        if (wen_b_s && (wa_b == ra_k)) begin
          rd[k*DW +: DW] = wd_b;
        end else if (wen_a_s && (wa_a == ra_k)) begin
          rd[k*DW +: DW] = wd_a;
        end else begin
          rd[k*DW +: DW] = mem_r[ra_k];
        end
      end else begin
        rd[k*DW +: DW] = '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance (DW=64, NREG=32, NRD=2) driven from a
// vector table with a storage model, plus a DW=32/NREG=24/NRD=4 instance.
module tb_regfile_mp;

  logic         clk;
  logic         reset_n;
  logic         we_a, we_b;
  logic [4:0]   wa_a, wa_b;
  logic [63:0]  wd_a, wd_b;
  logic [4:0]   ra0, ra1;
  logic [127:0] rd;
  logic         ready;

  logic         reset2_n;
  logic         we_a2, we_b2;
  logic [4:0]   wa_a2, wa_b2;
  logic [31:0]  wd_a2, wd_b2;
  logic [19:0]  ra2;
  logic [127:0] rd2;
  logic         ready2;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model [32];

  typedef struct {
    logic        we_a;
    logic [4:0]  wa_a;
    logic [63:0] wd_a;
    logic        we_b;
    logic [4:0]  wa_b;
    logic [63:0] wd_b;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [63:0] e0;
    logic [63:0] e1;
  } vec_t;

  vec_t vecs[12];

  regfile_mp u_dut (
    .clk(clk), .reset_n(reset_n),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .ra({ra1, ra0}), .rd(rd), .ready(ready)
  );

  regfile_mp #(.DW(32), .NREG(24), .NRD(4)) u_dut2 (
    .clk(clk), .reset_n(reset2_n),
    .we_a(we_a2), .wa_a(wa_a2), .wd_a(wd_a2),
    .we_b(we_b2), .wa_b(wa_b2), .wd_b(wd_b2),
    .ra(ra2), .rd(rd2), .ready(ready2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_rd(input logic [4:0] a);
    return (a == 5'd31) ? 64'd0 : model[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 64'(i);
  endtask

  // n edges after release; ready and reg5 readback must stay low until edge 32.
  task automatic count_init(input int n, input bit with_dut2);
    for (int e = 1; e <= n; e++) begin
      @(posedge clk);
      #1;
      chk("ready_init", {63'd0, ready}, (e == 32) ? 64'd1 : 64'd0);
      chk("rd0_init", rd[63:0], (e == 32) ? 64'd5 : 64'd0);
      if (with_dut2) begin
        chk("ready2_init", {63'd0, ready2}, (e >= 24) ? 64'd1 : 64'd0);
        if (e == 23) we_a2 = 1'b0;
      end
      if (e == 31) we_a = 1'b0;
    end
  endtask

  task automatic sweep(input string name);
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      ra0 = 5'(a);
      ra1 = 5'(31 - a);
      exp_q.push_back(model_rd(5'(a)));
      exp_q.push_back(model_rd(5'(31 - a)));
      #2;
      chk({name, "_p0"}, rd[63:0], exp_q.pop_front());
      chk({name, "_p1"}, rd[127:64], exp_q.pop_front());
    end
  endtask

  task automatic dut2_check(input logic [31:0] e0, e1, e2, e3);
    #2;
    chk("d2_p0", {32'd0, rd2[31:0]}, {32'd0, e0});
    chk("d2_p1", {32'd0, rd2[63:32]}, {32'd0, e1});
    chk("d2_p2", {32'd0, rd2[95:64]}, {32'd0, e2});
    chk("d2_p3", {32'd0, rd2[127:96]}, {32'd0, e3});
  endtask

  initial begin
    vecs[0]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,  5'd5,  5'd30, 64'd5,     64'd30};
    vecs[1]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,  5'd31, 5'd0,  64'd0,     64'd0};
    vecs[2]  = '{1'b1, 5'd3,  64'hDEAD, 1'b0, 5'd0,  64'h0,  5'd3,  5'd4,  64'hDEAD,  64'd4};
    vecs[3]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,  5'd3,  5'd3,  64'hDEAD,  64'hDEAD};
    vecs[4]  = '{1'b1, 5'd7,  64'h11,   1'b1, 5'd7,  64'h22, 5'd7,  5'd8,  64'h22,    64'd8};
    vecs[5]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,  5'd7,  5'd7,  64'h22,    64'h22};
    vecs[6]  = '{1'b1, 5'd31, 64'hFF,   1'b0, 5'd0,  64'h0,  5'd31, 5'd30, 64'd0,     64'd30};
    vecs[7]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,  5'd31, 5'd30, 64'd0,     64'd30};
    vecs[8]  = '{1'b1, 5'd10, 64'hA,    1'b1, 5'd11, 64'hB,  5'd10, 5'd11, 64'hA,     64'hB};
    vecs[9]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,  5'd10, 5'd11, 64'hA,     64'hB};
    vecs[10] = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd4};
    vecs[11] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,  5'd12, 5'd6,  64'hFFFF_FFFF_FFFF_FFFF, 64'd6};

    reset_n = 1'b0; reset2_n = 1'b0;
    we_a = 1'b1; wa_a = 5'd4; wd_a = 64'h55;
    we_b = 1'b0; wa_b = 5'd0; wd_b = 64'h0;
    ra0 = 5'd5; ra1 = 5'd30;
    we_a2 = 1'b1; wa_a2 = 5'd3; wd_a2 = 32'h99;
    we_b2 = 1'b0; wa_b2 = 5'd0; wd_b2 = 32'h0;
    ra2 = '0;
    model_reset();

    #32;
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_rd0", rd[63:0], 64'd0);
    chk("reset_ready2", {63'd0, ready2}, 64'd0);

    // Release both instances together; writes held high during INIT must be ignored.
    @(negedge clk);
    reset_n = 1'b1; reset2_n = 1'b1;
    count_init(32, 1'b1);

    // Table vectors: same-cycle expectations pushed at drive time, popped at sample time.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      we_a = vecs[i].we_a; wa_a = vecs[i].wa_a; wd_a = vecs[i].wd_a;
      we_b = vecs[i].we_b; wa_b = vecs[i].wa_b; wd_b = vecs[i].wd_b;
      ra0 = vecs[i].ra0; ra1 = vecs[i].ra1;
      exp_q.push_back(vecs[i].e0);
      exp_q.push_back(vecs[i].e1);
      if (vecs[i].we_a && vecs[i].wa_a != 5'd31) model[vecs[i].wa_a] = vecs[i].wd_a;
      if (vecs[i].we_b && vecs[i].wa_b != 5'd31) model[vecs[i].wa_b] = vecs[i].wd_b;
      #2;
      chk($sformatf("vec%0d_p0", i), rd[63:0], exp_q.pop_front());
      chk($sformatf("vec%0d_p1", i), rd[127:64], exp_q.pop_front());
    end
    @(negedge clk);
    we_a = 1'b0; we_b = 1'b0;
    sweep("after_vecs");

    // Reset mid-RUN with a write in flight: outputs drop without a clock edge.
    @(negedge clk);
    we_a = 1'b1; wa_a = 5'd20; wd_a = 64'h77;
    ra0 = 5'd5;
    reset_n = 1'b0;
    #1;
    chk("midrun_ready", {63'd0, ready}, 64'd0);
    chk("midrun_rd0", rd[63:0], 64'd0);
    repeat (2) @(negedge clk);
    we_a = 1'b0;
    reset_n = 1'b1;

    // Abort the sweep at idx=10, hold reset two cycles, then a full sweep must follow.
    count_init(10, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    count_init(32, 1'b0);
    model_reset();
    sweep("after_reinit");

    // Second instance: address 25 is beyond NREG=24; port B write bypasses to port 3.
    @(negedge clk);
    we_a2 = 1'b1; wa_a2 = 5'd25; wd_a2 = 32'h1234;
    we_b2 = 1'b1; wa_b2 = 5'd20; wd_b2 = 32'hCAFE;
    ra2 = {5'd20, 5'd5, 5'd23, 5'd25};
    dut2_check(32'd0, 32'd23, 32'd5, 32'hCAFE);
    @(negedge clk);
    we_a2 = 1'b0; we_b2 = 1'b0;
    dut2_check(32'd0, 32'd23, 32'd5, 32'hCAFE);
    @(negedge clk);
    ra2 = {5'd20, 5'd20, 5'd20, 5'd20};
    dut2_check(32'hCAFE, 32'hCAFE, 32'hCAFE, 32'hCAFE);
    @(negedge clk);
    ra2 = {5'd3, 5'd25, 5'd25, 5'd0};
    dut2_check(32'd0, 32'd0, 32'd0, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
